// File: rtl/ram_delay_pkg.sv
// Shared definitions for the RAM-backed delay line family.
//   N_DELAY_MIN : smallest delay n_r may hold (requested 0 is raised to this)
//   sum_width() : width of the moving-sum output (data bits + address bits)
package ram_delay_pkg;

   localparam int unsigned N_DELAY_MIN = 1;

   // n_r*(2^D-1) < 2^(D+A), so D+A bits never overflow
   function automatic int unsigned sum_width(input int unsigned nbits_data,
                                             input int unsigned nbits_addr);
      return nbits_data + nbits_addr;
   endfunction

endpackage

// File: rtl/ram_delay_sum_if.sv
// Sample/result bundle of ram_delay_sum.
//   master : drives flush, n, wr, d; receives qn, qo, out_stb, valid, sum, sum_stb
//   slave  : the delay line itself
interface ram_delay_sum_if
   import ram_delay_pkg::*;
#(
   parameter int unsigned P_NBITS_DATA = 42,
   parameter int unsigned P_NBITS_ADDR = 9
) ();

   localparam int unsigned S = sum_width(P_NBITS_DATA, P_NBITS_ADDR);

   logic                    flush;
   logic [P_NBITS_ADDR-1:0] n;
   logic                    wr;
   logic [P_NBITS_DATA-1:0] d;
   logic [P_NBITS_DATA-1:0] qn;
   logic [P_NBITS_DATA-1:0] qo;
   logic                    out_stb;
   logic                    valid;
   logic [S-1:0]            sum;
   logic                    sum_stb;

   modport master (output flush, n, wr, d,
                   input  qn, qo, out_stb, valid, sum, sum_stb);

   modport slave  (input  flush, n, wr, d,
                   output qn, qo, out_stb, valid, sum, sum_stb);

endinterface

// File: rtl/ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read request; rdata updates on the next edge, holds otherwise
//   rdata        : read data (not reset; contents are never cleared)
module ram_sdp #(
   parameter int unsigned P_NBITS_DATA = 42,
   parameter int unsigned P_NBITS_ADDR = 9
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [P_NBITS_ADDR-1:0] waddr,
   input  logic [P_NBITS_DATA-1:0] wdata,
   input  logic                    re,
   input  logic [P_NBITS_ADDR-1:0] raddr,
   output logic [P_NBITS_DATA-1:0] rdata
);

   localparam int unsigned DEPTH = 1 << P_NBITS_ADDR;

   logic [P_NBITS_DATA-1:0] mem [DEPTH];

   // write port and registered read port
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata      <= mem[raddr];
   end

endmodule

// File: rtl/ram_delay_sum.sv
// Programmable RAM delay line with moving sum.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of ram_delay_sum_if
//              qn = newest sample, qo = sample n_r writes earlier (0 until full),
//              valid = line full, sum = sum of last min(k, n_r) samples
module ram_delay_sum
   import ram_delay_pkg::*;
#(
   parameter int unsigned P_NBITS_DATA = 42,
   parameter int unsigned P_NBITS_ADDR = 9,
   parameter bit          P_SUM_EN     = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   ram_delay_sum_if.slave bus
);

   localparam int unsigned D = P_NBITS_DATA;
   localparam int unsigned A = P_NBITS_ADDR;
   localparam int unsigned S = sum_width(D, A);

   logic [A-1:0] n_r;
   logic [A-1:0] wp;
   logic [A-1:0] cnt;
   logic [A-1:0] raddr_c;
   logic         full_c;
   logic         wr_ok_c;
   logic         qo_sel;
   logic         valid_r;
   logic         out_stb_r;
   logic [D-1:0] qn_r;
   logic [D-1:0] rdata;
   logic [D-1:0] qo_c;

   assign wr_ok_c = bus.wr & ~bus.flush & ~rst;
   assign full_c  = (cnt == n_r);
   assign raddr_c = wp - n_r;

   // delay latch: follows n while rst/flush is high, 0 clamps to the minimum
   always_ff @(posedge clk) begin
      if (rst || bus.flush) n_r <= (bus.n == '0) ? A'(N_DELAY_MIN) : bus.n;
   end

   // pointer, fill count and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wp        <= '0;
         cnt       <= '0;
         valid_r   <= 1'b0;
         out_stb_r <= 1'b0;
         qn_r      <= '0;
         qo_sel    <= 1'b0;
      end else if (bus.flush) begin
         // qn/qo hold across a flush
         wp        <= '0;
         cnt       <= '0;
         valid_r   <= 1'b0;
         out_stb_r <= 1'b0;
      end else begin
         out_stb_r <= bus.wr;
         if (bus.wr) begin
            wp     <= wp + A'(1);
            qn_r   <= bus.d;
            qo_sel <= full_c;
            if (full_c) valid_r <= 1'b1;
            else        cnt     <= cnt + A'(1);
         end
      end
   end

   ram_sdp #(
      .P_NBITS_DATA (D),
      .P_NBITS_ADDR (A)
   ) u_ram (
      .clk   (clk),
      .we    (wr_ok_c),
      .waddr (wp),
      .wdata (bus.d),
      .re    (wr_ok_c),
      .raddr (raddr_c),
      .rdata (rdata)
   );

   // qo_sel is a register that only moves on writes and rst, so qo holds on flush
   assign qo_c        = qo_sel ? rdata : '0;
   assign bus.qn      = qn_r;
   assign bus.qo      = qo_c;
   assign bus.valid   = valid_r;
   assign bus.out_stb = out_stb_r;

   generate
      if (P_SUM_EN) begin : g_sum
         logic [S-1:0] sum_r;
         logic         sum_stb_r;

         // running sum: add newest, drop the one leaving the window
         always_ff @(posedge clk) begin
            if (rst || bus.flush) begin
               sum_r     <= '0;
               sum_stb_r <= 1'b0;
            end else begin
               sum_stb_r <= out_stb_r;
               if (out_stb_r) sum_r <= sum_r + S'(qn_r) - S'(qo_c);
            end
         end

         assign bus.sum     = sum_r;
         assign bus.sum_stb = sum_stb_r;
      end else begin : g_no_sum
         assign bus.sum     = '0;
         assign bus.sum_stb = 1'b0;
      end
   endgenerate

endmodule

// File: tb/tb_ram_delay_sum.sv
module tb_ram_delay_sum;
   import ram_delay_pkg::*;

   localparam int unsigned D = 42;
   localparam int unsigned A = 9;
   localparam int unsigned S = sum_width(D, A);

   typedef struct {
      logic [D-1:0] d;
      logic [D-1:0] qn;
      logic [D-1:0] qo;
      logic         valid;
      logic [S-1:0] sum;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ram_delay_sum_if #(.P_NBITS_DATA(D), .P_NBITS_ADDR(A)) bus ();

   ram_delay_sum #(.P_NBITS_DATA(D), .P_NBITS_ADDR(A), .P_SUM_EN(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int           tests = 0;
   int           fails = 0;
   logic         pend;
   logic [S-1:0] pend_sum;
   vec_t         ramp [20];
   vec_t         fl   [5];
   vec_t         vz;
   int           stb_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // one clock: drive inputs, sample #1 after the edge
   task automatic step(input logic r, input logic f, input logic w,
                       input logic [D-1:0] dv, input vec_t v);
      rst = r; bus.flush = f; bus.wr = w; bus.d = dv;
      @(posedge clk); #1;
      if (r || f) begin
         chk("out_stb_clr", 64'(bus.out_stb), 64'(0));
         chk("sum_stb_clr", 64'(bus.sum_stb), 64'(0));
         chk("sum_clr",     64'(bus.sum),     64'(0));
         chk("valid_clr",   64'(bus.valid),   64'(0));
         if (r) begin
            chk("qn_rst", 64'(bus.qn), 64'(0));
            chk("qo_rst", 64'(bus.qo), 64'(0));
         end
         pend = 1'b0;
      end else begin
         chk("sum_stb", 64'(bus.sum_stb), 64'(pend));
         if (pend) chk("sum", 64'(bus.sum), 64'(pend_sum));
         chk("out_stb", 64'(bus.out_stb), 64'(w));
         if (bus.out_stb) stb_cnt++;
         if (w) begin
            chk("qn",    64'(bus.qn),    64'(v.qn));
            chk("qo",    64'(bus.qo),    64'(v.qo));
            chk("valid", 64'(bus.valid), 64'(v.valid));
         end
         pend     = w;
         pend_sum = v.sum;
      end
   endtask

   task automatic run_ramp(input bit gapped);
      stb_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         bus.n = A'(5);  // ignored outside rst/flush
         step(1'b0, 1'b0, 1'b1, ramp[i].d, ramp[i]);
         if (gapped) step(1'b0, 1'b0, 1'b0, '0, vz);
      end
      step(1'b0, 1'b0, 1'b0, '0, vz);
      chk("ramp_final_sum", 64'(bus.sum), 64'(184));
      chk("ramp_stb_count", 64'(stb_cnt), 64'(20));
   endtask

   initial begin
      logic [S-1:0] s;
      logic [D-1:0] ones;
      vec_t         v;

      bus.flush = 1'b0; bus.wr = 1'b0; bus.d = '0; bus.n = A'(16);
      pend = 1'b0; pend_sum = '0; stb_cnt = 0;
      vz = '{d: '0, qn: '0, qo: '0, valid: 1'b0, sum: '0};

      // ramp table, n = 16
      s = '0;
      for (int i = 0; i < 20; i++) begin
         s = s + S'(i);
         if (i >= 16) s = s - S'(i - 16);
         ramp[i] = '{d: D'(i), qn: D'(i), qo: (i >= 16) ? D'(i - 16) : D'(0),
                     valid: (i >= 16), sum: s};
      end
      // flush/relatch table, n = 4, data 100..104
      fl[0] = '{d: D'(100), qn: D'(100), qo: D'(0),   valid: 1'b0, sum: S'(100)};
      fl[1] = '{d: D'(101), qn: D'(101), qo: D'(0),   valid: 1'b0, sum: S'(201)};
      fl[2] = '{d: D'(102), qn: D'(102), qo: D'(0),   valid: 1'b0, sum: S'(303)};
      fl[3] = '{d: D'(103), qn: D'(103), qo: D'(0),   valid: 1'b0, sum: S'(406)};
      fl[4] = '{d: D'(104), qn: D'(104), qo: D'(100), valid: 1'b1, sum: S'(410)};

      // reset state
      step(1'b1, 1'b0, 1'b0, '0, vz);
      step(1'b1, 1'b0, 1'b0, '0, vz);

      // back-to-back ramp
      run_ramp(1'b0);

      // gapped ramp
      bus.n = A'(16);
      step(1'b0, 1'b1, 1'b0, '0, vz);
      run_ramp(1'b1);

      // reset mid-stream with wr held high, then refill
      bus.n = A'(16);
      step(1'b0, 1'b1, 1'b0, '0, vz);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, ramp[i].d, ramp[i]);
      bus.n = A'(16);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, D'(77), vz);
      run_ramp(1'b0);

      // flush and relatch to n = 4; wr during flush is dropped
      bus.n = A'(16);
      step(1'b0, 1'b1, 1'b0, '0, vz);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, ramp[i].d, ramp[i]);
      bus.n = A'(4);
      step(1'b0, 1'b1, 1'b1, D'(55), vz);
      chk("flush_qn_hold", 64'(bus.qn), 64'(9));
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, fl[i].d, fl[i]);
      step(1'b0, 1'b0, 1'b0, '0, vz);
      chk("flush_final_sum", 64'(bus.sum), 64'(410));

      // n = 0 clamps to 1
      bus.n = A'(0);
      step(1'b0, 1'b1, 1'b0, '0, vz);
      v = '{d: D'(7), qn: D'(7), qo: D'(0), valid: 1'b0, sum: S'(7)};
      step(1'b0, 1'b0, 1'b1, v.d, v);
      v = '{d: D'(9), qn: D'(9), qo: D'(7), valid: 1'b1, sum: S'(9)};
      step(1'b0, 1'b0, 1'b1, v.d, v);
      step(1'b0, 1'b0, 1'b0, '0, vz);
      chk("clamp_sum", 64'(bus.sum), 64'(9));

      // n = 511, full-scale data, pointer wraps twice
      ones  = '1;
      bus.n = A'(511);
      step(1'b0, 1'b1, 1'b0, '0, vz);
      for (int i = 0; i < 1200; i++) begin
         v.d     = ones;
         v.qn    = ones;
         v.qo    = (i >= 511) ? ones : D'(0);
         v.valid = (i >= 511);
         v.sum   = S'(((i >= 511) ? 511 : i + 1)) * S'(ones);
         step(1'b0, 1'b0, 1'b1, v.d, v);
      end
      step(1'b0, 1'b0, 1'b0, '0, vz);
      chk("wide_final_sum", 64'(bus.sum), 64'(S'(511) * S'(ones)));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
